// File: rtl/multdiv_ctrl_if.sv
// -----------------------------------------------------------------------------
// multdiv_ctrl_if
//   Bundles every signal between the mult/div sequencer and its neighbours:
//   the execute-stage request/response and the shared multiplier/divider units.
//
//   Request side   : ctrl_MULT, ctrl_DIV, data_operandA/B, ctrl_tag
//   Unit drive     : unit_operandA/B, mult_clr, div_clr
//   Unit return    : mult_result/exception/resultRDY, div_result/exception/resultRDY
//   Response side  : data_result, data_exception, data_resultRDY, result_tag, busy
//
//   slave  - the sequencer's view (multdiv_ctrl)
//   master - the surroundings' view (pipeline plus the two units)
// -----------------------------------------------------------------------------
interface multdiv_ctrl_if #(
  parameter int TAG_W = 5
);

  // execute-stage request
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [31:0]      data_operandA;
  logic [31:0]      data_operandB;
  logic [TAG_W-1:0] ctrl_tag;

  // drive towards the units
  logic [31:0]      unit_operandA;
  logic [31:0]      unit_operandB;
  logic             mult_clr;
  logic             div_clr;

  // unit results
  logic [31:0]      mult_result;
  logic             mult_exception;
  logic             mult_resultRDY;
  logic [31:0]      div_result;
  logic             div_exception;
  logic             div_resultRDY;

  // completion back to the pipeline
  logic [31:0]      data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic [TAG_W-1:0] result_tag;
  logic             busy;

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, ctrl_tag,
    input  mult_result, mult_exception, mult_resultRDY,
    input  div_result, div_exception, div_resultRDY,
    output unit_operandA, unit_operandB, mult_clr, div_clr,
    output data_result, data_exception, data_resultRDY, result_tag, busy
  );

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, ctrl_tag,
    output mult_result, mult_exception, mult_resultRDY,
    output div_result, div_exception, div_resultRDY,
    input  unit_operandA, unit_operandB, mult_clr, div_clr,
    input  data_result, data_exception, data_resultRDY, result_tag, busy
  );

endinterface

// File: rtl/multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// multdiv_ctrl
//   Shares one multi-cycle multiplier and one multi-cycle divider between
//   pipeline requests. One MULT or DIV is accepted at a time (only in IDLE);
//   operands and destination tag are latched, the selected unit is released
//   from clear, and the controller waits for that unit's ready or a timeout.
//   The result, exception and tag are registered and announced with a
//   one-cycle data_resultRDY strobe. busy stalls the pipeline whenever the
//   controller is not idle. No arithmetic is done here.
//
//   Parameters
//     TIMEOUT : RUN cycles allowed before forced completion with exception (2..63)
//     TAG_W   : width of the destination register tag
//
//   Ports
//     clock   : system clock, rising edge
//     reset   : asynchronous, active-high reset
//     bus     : multdiv_ctrl_if.slave - request, unit and response signals
// -----------------------------------------------------------------------------
module multdiv_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int TAG_W   = 5
) (
  input  logic           clock,
  input  logic           reset,
  multdiv_ctrl_if.slave  bus
);

  // TIMEOUT is at most 63, so six bits always hold TIMEOUT-1.
  localparam int                CNT_W    = 6;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

  state_t            state;
  state_t            next_state;
  op_t               op;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [31:0]       opa_q;
  logic [31:0]       opb_q;
  logic [TAG_W-1:0]  tag_q;
  logic [31:0]       result_q;
  logic              exception_q;
  logic [TAG_W-1:0]  result_tag_q;

  logic              accept;
  logic              reject_both;
  logic              unit_done;
  logic              timed_out;
  logic              sel_rdy;
  logic [31:0]       sel_result;
  logic              sel_exception;

  // Only the unit that owns the current operation is listened to; the other
  // unit is held in clear and anything it reports is ignored.
  assign sel_rdy       = (op == OP_DIV) ? bus.div_resultRDY  : bus.mult_resultRDY;
  assign sel_result    = (op == OP_DIV) ? bus.div_result     : bus.mult_result;
  assign sel_exception = (op == OP_DIV) ? bus.div_exception  : bus.mult_exception;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. The event flags are consumed by the datapath registers
  // below. A ready in the final allowed RUN cycle is taken as a normal
  // completion, so it is checked before the timeout.
  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    reject_both = 1'b0;
    unit_done   = 1'b0;
    timed_out   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ctrl_MULT ^ bus.ctrl_DIV) begin
          accept     = 1'b1;
          next_state = RUN;
        end else if (bus.ctrl_MULT && bus.ctrl_DIV) begin
          reject_both = 1'b1;
          next_state  = DONE;
        end
      end
      RUN: begin
        if (sel_rdy) begin
          unit_done  = 1'b1;
          next_state = DONE;
        end else if (cycle_cnt == LAST_CNT) begin
          timed_out  = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request latch and cycle counter. Operands and tag only change on an
  // accepted single request; a simultaneous MULT+DIV leaves them alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op        <= OP_MULT;
      cycle_cnt <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      tag_q     <= '0;
    end else if (accept) begin
      op        <= bus.ctrl_DIV ? OP_DIV : OP_MULT;
      cycle_cnt <= '0;
      opa_q     <= bus.data_operandA;
      opb_q     <= bus.data_operandB;
      tag_q     <= bus.ctrl_tag;
    end else if (state == RUN) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  // Completion registers. They are loaded only on the way into DONE and
  // otherwise hold, so the pipeline can read them after the strobe.
  // A timeout still reports the tag of the operation it abandons.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_q     <= '0;
      exception_q  <= 1'b0;
      result_tag_q <= '0;
    end else if (reject_both) begin
      result_q     <= '0;
      exception_q  <= 1'b1;
      result_tag_q <= bus.ctrl_tag;
    end else if (unit_done) begin
      result_q     <= sel_result;
      exception_q  <= sel_exception;
      result_tag_q <= tag_q;
    end else if (timed_out) begin
      result_q     <= '0;
      exception_q  <= 1'b1;
      result_tag_q <= tag_q;
    end
  end

  // The unit not running the current operation is kept in clear so its
  // internal counter sits at zero until it is next selected.
  assign bus.mult_clr       = !((state == RUN) && (op == OP_MULT));
  assign bus.div_clr        = !((state == RUN) && (op == OP_DIV));

  assign bus.unit_operandA  = opa_q;
  assign bus.unit_operandB  = opb_q;
  assign bus.data_result    = result_q;
  assign bus.data_exception = exception_q;
  assign bus.result_tag     = result_tag_q;
  assign bus.data_resultRDY = (state == DONE);
  assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multdiv_ctrl
//   Bench for multdiv_ctrl with behavioural multiplier/divider stubs whose
//   latency, stall and "noise on the idle unit" can be set per operation.
//   Expected completion timing: the selected unit reports ready in RUN cycle
//   L (counted from 0); a timeout fires in RUN cycle TIMEOUT-1; the strobe
//   is seen at the negedge min(L, TIMEOUT-1) + 2 after the accept edge.
// -----------------------------------------------------------------------------
module tb_multdiv_ctrl;

  localparam int TIMEOUT = 40;
  localparam int TAG_W   = 5;
  localparam int NO_LAT  = 1000;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  multdiv_ctrl_if #(.TAG_W(TAG_W)) bus ();

  multdiv_ctrl #(
    .TIMEOUT (TIMEOUT),
    .TAG_W   (TAG_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  // ---------------------------------------------------------------------------
  // Unit stubs: arithmetic reference of the real units
  // ---------------------------------------------------------------------------
  function automatic logic [32:0] mult_unit(input logic [31:0] a, input logic [31:0] b);
    longint pa, pb, p;
    logic [31:0] lo;
    logic ovf;
    pa  = longint'($signed(a));
    pb  = longint'($signed(b));
    p   = pa * pb;
    lo  = p[31:0];
    ovf = (p != longint'($signed(lo)));
    return {ovf, lo};
  endfunction

  function automatic logic [32:0] div_unit(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q;
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'd0};
    sa = a;
    sb = b;
    q  = sa / sb;
    return {1'b0, q};
  endfunction

  int   mult_lat = 0, div_lat = 0;
  bit   mult_stall = 0, div_stall = 0;
  bit   mult_junk = 0, div_junk = 0;
  int   mult_cnt = 0, div_cnt = 0;
  logic [32:0] m_out, d_out;

  always @(posedge clock) begin
    if (bus.mult_clr) mult_cnt <= 0; else mult_cnt <= mult_cnt + 1;
    if (bus.div_clr)  div_cnt  <= 0; else div_cnt  <= div_cnt + 1;
  end

  assign m_out = mult_unit(bus.unit_operandA, bus.unit_operandB);
  assign d_out = div_unit(bus.unit_operandA, bus.unit_operandB);

  assign bus.mult_result    = m_out[31:0] ^ (mult_junk ? 32'hDEAD_BEEF : 32'd0);
  assign bus.mult_exception = m_out[32] | mult_junk;
  assign bus.mult_resultRDY = mult_junk || (!bus.mult_clr && !mult_stall && mult_cnt >= mult_lat);
  assign bus.div_result     = d_out[31:0] ^ (div_junk ? 32'hBAD0_F00D : 32'd0);
  assign bus.div_exception  = d_out[32] | div_junk;
  assign bus.div_resultRDY  = div_junk || (!bus.div_clr && !div_stall && div_cnt >= div_lat);

  // ---------------------------------------------------------------------------
  // Vector record
  // ---------------------------------------------------------------------------
  typedef struct {
    bit               do_mult;
    bit               do_div;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    int               lat;
    bit               stall;
    bit               junk;
    logic [31:0]      exp_result;
    bit               exp_exc;
    logic [TAG_W-1:0] exp_tag;
    int               exp_cycles;
    bit               chk_tag;
  } vec_t;

  logic [31:0] last_opa = 32'd0;
  logic [31:0] last_opb = 32'd0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: outcome of one request from the operation rules alone.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic [32:0] u;
    int eff;
    r = v;
    if (v.do_mult && v.do_div) begin
      r.exp_result = 32'd0; r.exp_exc = 1'b1; r.exp_tag = v.tag;
      r.exp_cycles = 1;     r.chk_tag = 1'b1;
    end else begin
      u   = v.do_div ? div_unit(v.a, v.b) : mult_unit(v.a, v.b);
      eff = v.stall ? NO_LAT : v.lat;
      if (eff <= TIMEOUT - 1) begin
        r.exp_result = u[31:0]; r.exp_exc = u[32]; r.exp_tag = v.tag;
        r.exp_cycles = eff + 2; r.chk_tag = 1'b1;
      end else begin
        r.exp_result = 32'd0;   r.exp_exc = 1'b1; r.exp_tag = v.tag;
        r.exp_cycles = TIMEOUT + 1; r.chk_tag = 1'b0;
      end
    end
    return r;
  endfunction

  // Issues one request (caller sits at a negedge in IDLE), follows it to
  // completion and checks timing, payload, clears and busy. Returns at the
  // first idle negedge after the strobe so back-to-back issue is possible.
  task automatic apply_stimulus(input string nm, input vec_t v);
    int n;
    bit got, clr_ok, busy_ok, single;
    logic [31:0] exp_opa, exp_opb;
    single     = v.do_mult ^ v.do_div;
    mult_lat   = v.lat;  div_lat   = v.lat;
    mult_stall = v.stall; div_stall = v.stall;
    mult_junk  = v.junk && v.do_div && !v.do_mult;
    div_junk   = v.junk && v.do_mult && !v.do_div;
    bus.ctrl_MULT     = v.do_mult;
    bus.ctrl_DIV      = v.do_div;
    bus.data_operandA = v.a;
    bus.data_operandB = v.b;
    bus.ctrl_tag      = v.tag;
    exp_opa = single ? v.a : last_opa;
    exp_opb = single ? v.b : last_opb;
    n = 0; got = 0; clr_ok = 1; busy_ok = 1;
    while (!got && n < 100) begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        bus.ctrl_tag      = TAG_W'($urandom);
      end
      if (bus.data_resultRDY) begin
        got = 1;
      end else begin
        if (bus.busy !== 1'b1) busy_ok = 0;
        if (bus.mult_clr !== !v.do_mult) clr_ok = 0;
        if (bus.div_clr  !== !v.do_div)  clr_ok = 0;
      end
    end
    mult_junk = 0; div_junk = 0;
    if (!got) begin
      check_output({nm, ".strobe_seen"}, 64'd0, 64'd1);
      return;
    end
    check_output({nm, ".cycles"}, 64'(n), 64'(v.exp_cycles));
    check_output({nm, ".result"}, 64'(bus.data_result), 64'(v.exp_result));
    check_output({nm, ".exception"}, 64'(bus.data_exception), 64'(v.exp_exc));
    if (v.chk_tag) check_output({nm, ".tag"}, 64'(bus.result_tag), 64'(v.exp_tag));
    check_output({nm, ".opA"}, 64'(bus.unit_operandA), 64'(exp_opa));
    check_output({nm, ".opB"}, 64'(bus.unit_operandB), 64'(exp_opb));
    if (bus.busy !== 1'b1) busy_ok = 0;
    if (bus.mult_clr !== 1'b1 || bus.div_clr !== 1'b1) clr_ok = 0;
    last_opa = exp_opa;
    last_opb = exp_opb;
    @(negedge clock);
    check_output({nm, ".strobe_len"}, 64'(bus.data_resultRDY), 64'd0);
    check_output({nm, ".busy_after"}, 64'(bus.busy), 64'd0);
    check_output({nm, ".result_hold"}, 64'(bus.data_result), 64'(v.exp_result));
    check_output({nm, ".clr_pattern"}, 64'(clr_ok), 64'd1);
    check_output({nm, ".busy_during"}, 64'(busy_ok), 64'd1);
  endtask

  task automatic check_reset_state(input string nm);
    check_output({nm, ".busy"},   64'(bus.busy), 64'd0);
    check_output({nm, ".rdy"},    64'(bus.data_resultRDY), 64'd0);
    check_output({nm, ".result"}, 64'(bus.data_result), 64'd0);
    check_output({nm, ".exc"},    64'(bus.data_exception), 64'd0);
    check_output({nm, ".tag"},    64'(bus.result_tag), 64'd0);
    check_output({nm, ".opA"},    64'(bus.unit_operandA), 64'd0);
    check_output({nm, ".opB"},    64'(bus.unit_operandB), 64'd0);
    check_output({nm, ".clrs"},   64'({bus.mult_clr, bus.div_clr}), 64'd3);
  endtask

  vec_t table_v[8];

  initial begin
    vec_t v;
    int n, strobes;
    bit got;

    reset = 1'b1;
    bus.ctrl_MULT = 0; bus.ctrl_DIV = 0;
    bus.data_operandA = 0; bus.data_operandB = 0; bus.ctrl_tag = 0;

    //                do_m do_d a              b              tag lat st jk  exp_res        exc tag cyc chk
    table_v[0] = '{0, 1, 32'd100,        32'hFFFF_FFF9, 5'd9, 31, 0, 1, 32'hFFFF_FFF2, 0, 5'd9, 33, 1};
    table_v[1] = '{0, 1, 32'd5,          32'd0,         5'd1, 31, 0, 0, 32'd0,         1, 5'd1, 33, 1};
    table_v[2] = '{1, 0, 32'd6,          32'd7,         5'd3, 16, 0, 1, 32'd42,        0, 5'd3, 18, 1};
    table_v[3] = '{1, 1, 32'd11,         32'd12,        5'd4, 5,  0, 0, 32'd0,         1, 5'd4, 1,  1};
    table_v[4] = '{0, 1, 32'd77,         32'd3,         5'd7, 0,  1, 0, 32'd0,         1, 5'd7, 41, 0};
    table_v[5] = '{1, 0, 32'd3,          32'hFFFF_FFFB, 5'd2, 39, 0, 0, 32'hFFFF_FFF1, 0, 5'd2, 41, 1};
    table_v[6] = '{1, 0, 32'd8,          32'd9,         5'd6, 40, 0, 0, 32'd0,         1, 5'd6, 41, 0};
    table_v[7] = '{1, 0, 32'h0001_0000,  32'h0001_0000, 5'd5, 0,  0, 0, 32'd0,         1, 5'd5, 2,  1};

    repeat (2) @(negedge clock);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      apply_stimulus($sformatf("table%0d", i), table_v[i]);
    end

    // MULT with a DIV request pulsed mid-RUN: must be ignored, not queued.
    $display("[TB] ignored-request sequence");
    mult_lat = 16; mult_stall = 0;
    bus.ctrl_MULT = 1; bus.data_operandA = 32'd6; bus.data_operandB = 32'd7; bus.ctrl_tag = 5'd3;
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clock);
      n++;
      bus.ctrl_MULT = 0;
      if (n == 5) begin
        bus.ctrl_DIV = 1; bus.data_operandA = 32'd99; bus.data_operandB = 32'd1; bus.ctrl_tag = 5'd20;
      end else begin
        bus.ctrl_DIV = 0;
      end
      if (bus.data_resultRDY) got = 1;
    end
    check_output("ignore.cycles", 64'(n), 64'd18);
    check_output("ignore.result", 64'(bus.data_result), 64'd42);
    check_output("ignore.tag",    64'(bus.result_tag), 64'd3);
    check_output("ignore.opA",    64'(bus.unit_operandA), 64'd6);
    strobes = 0;
    repeat (45) begin
      @(negedge clock);
      if (bus.data_resultRDY) strobes++;
    end
    check_output("ignore.extra_strobes", 64'(strobes), 64'd0);
    last_opa = 32'd6; last_opb = 32'd7;

    // Reset in cycle 10 of a DIV: discard the operation, no late strobe.
    $display("[TB] mid-operation reset sequence");
    div_lat = 31; div_stall = 0;
    bus.ctrl_DIV = 1; bus.data_operandA = 32'd100; bus.data_operandB = 32'd3; bus.ctrl_tag = 5'd11;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      bus.ctrl_DIV = 0;
    end
    check_output("midreset.div_clr_before", 64'(bus.div_clr), 64'd0);
    reset = 1'b1;
    #1;
    check_reset_state("midreset");
    @(negedge clock);
    reset = 1'b0;
    strobes = 0;
    repeat (45) begin
      @(negedge clock);
      if (bus.data_resultRDY || bus.busy) strobes++;
    end
    check_output("midreset.no_strobe", 64'(strobes), 64'd0);
    last_opa = 32'd0; last_opb = 32'd0;

    // Randomized back-to-back traffic against the reference model.
    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      v = '{default: 0};
      v.do_div  = ($urandom_range(0, 1) == 1);
      v.do_mult = !v.do_div || ($urandom_range(0, 7) == 0);
      v.a       = $urandom;
      case ($urandom_range(0, 3))
        0:       v.b = 32'd0;
        1:       v.b = $urandom_range(1, 20);
        2:       v.b = -($urandom_range(1, 20));
        default: v.b = $urandom;
      endcase
      v.tag   = TAG_W'($urandom);
      v.lat   = $urandom_range(0, 45);
      v.stall = ($urandom_range(0, 7) == 0);
      v.junk  = ($urandom_range(0, 1) == 1);
      apply_stimulus($sformatf("rand%0d", i), model(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
